// File: rtl/pool2d_stream_if.sv
// ============================================================================
// Module : pool2d_stream_if
// Brief  : Pixel-in / pooled-pixel-out handshake bundle for pool2d_stream.
//          The master side is the producer/consumer environment and the
//          slave side is the pooling engine.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface pool2d_stream_if #(
    parameter int DW = 8
);
    logic          mode;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          frame_done;
    logic          busy;

    modport master (
        output mode, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, frame_done, busy
    );

    modport slave (
        input  mode, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, frame_done, busy
    );
endinterface

`default_nettype wire

// File: rtl/pool2d_stream.sv
// ============================================================================
// Module : pool2d_stream
// Brief  : Streaming K x K, stride S, MAX/AVG pooling over a raster-order
//          pixel stream. K-1 line buffers feed a K x K window register; one
//          pooled pixel is produced per fully covered window position.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module pool2d_stream #(
    parameter int DW    = 8,
    parameter int IMG_W = 8,
    parameter int IMG_H = 8,
    parameter int K     = 3,
    parameter int S     = 1
) (
    input wire            clk,
    input wire            rst,     // asynchronous, active-low
    pool2d_stream_if.slave s
);

    localparam int OW   = (IMG_W - K) / S + 1;
    localparam int OH   = (IMG_H - K) / S + 1;
    localparam int NOUT = OW * OH;
    localparam int CW   = $clog2(IMG_W);
    localparam int RW   = $clog2(IMG_H);
    localparam int OCW  = $clog2(NOUT + 1);
    localparam int SW   = DW + $clog2(K * K);

    localparam logic [CW-1:0]  C_LAST_COL = CW'(IMG_W - 1);
    localparam logic [RW-1:0]  C_LAST_ROW = RW'(IMG_H - 1);
    localparam logic [OCW-1:0] C_LAST_OUT = OCW'(NOUT - 1);
    localparam int unsigned    C_K1       = K - 1;
    localparam int unsigned    C_S        = S;

    // Reject geometries where no full window fits or the stride skips pixels.
    if (K > IMG_W || K > IMG_H || S < 1 || S > K) begin : g_bad_params
        $error("pool2d_stream: illegal K/S for the configured image size");
    end

    logic [RW-1:0]  row_q, row_d;
    logic [CW-1:0]  col_q, col_d;
    logic           mode_q, mode_d;
    logic           busy_q, busy_d;
    logic [OCW-1:0] ocnt_q, ocnt_d;
    logic           out_valid_q, out_valid_d;
    logic [DW-1:0]  out_data_q, out_data_d;
    logic           frame_done_q, frame_done_d;

    // lb_q[0] holds the previous row, lb_q[K-2] the oldest buffered row.
    logic [DW-1:0]  lb_q  [K-1][IMG_W];
    logic [DW-1:0]  win_q [K][K];
    logic [DW-1:0]  win_d [K][K];
    logic [DW-1:0]  win_max;
    logic [SW-1:0]  win_sum;

    logic accept, out_hs, row_ok, col_ok, emit;

    assign s.in_ready = !out_valid_q || s.out_ready;
    assign accept     = s.in_valid && s.in_ready;
    assign out_hs     = out_valid_q && s.out_ready;

    assign row_ok = (32'(row_q) >= C_K1) && (((32'(row_q) - C_K1) % C_S) == 0);
    assign col_ok = (32'(col_q) >= C_K1) && (((32'(col_q) - C_K1) % C_S) == 0);
    assign emit   = row_ok && col_ok;

    assign s.out_valid  = out_valid_q;
    assign s.out_data   = out_data_q;
    assign s.frame_done = frame_done_q;
    assign s.busy       = busy_q;

    // Next window: shift columns left, new rightmost column from line buffers + input.
    always_comb begin
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K - 1; c++) begin
                win_d[r][c] = win_q[r][c+1];
            end
        end
        for (int r = 0; r < K - 1; r++) begin
            win_d[r][K-1] = lb_q[K-2-r][col_q];
        end
        win_d[K-1][K-1] = s.in_data;
    end

    // Max and full-precision sum over the window that includes the current pixel.
    always_comb begin
        win_max = '0;
        win_sum = '0;
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K; c++) begin
                if (win_d[r][c] > win_max) win_max = win_d[r][c];
                win_sum = win_sum + SW'(win_d[r][c]);
            end
        end
    end

    // Line buffer and window storage; contents never need clearing.
    always_ff @(posedge clk) begin
        if (accept) begin
            win_q <= win_d;
            lb_q[0][col_q] <= s.in_data;
            for (int j = 1; j < K - 1; j++) begin
                lb_q[j][col_q] <= lb_q[j-1][col_q];
            end
        end
    end

    // Next-state for counters, frame tracking and the single output register.
    always_comb begin
        row_d        = row_q;
        col_d        = col_q;
        mode_d       = mode_q;
        busy_d       = busy_q;
        ocnt_d       = ocnt_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        frame_done_d = 1'b0;

        if (out_hs) begin
            out_valid_d = 1'b0;
            if (ocnt_q == C_LAST_OUT) begin
                ocnt_d       = '0;
                frame_done_d = 1'b1;
                busy_d       = 1'b0;
            end else begin
                ocnt_d = ocnt_q + 1'b1;
            end
        end

        if (accept) begin
            if (row_q == '0 && col_q == '0) begin
                mode_d = s.mode;
                busy_d = 1'b1;
            end
            if (col_q == C_LAST_COL) begin
                col_d = '0;
                row_d = (row_q == C_LAST_ROW) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
            // The first pixel of a frame never completes a window, so mode_q is settled here.
            if (emit) begin
                out_valid_d = 1'b1;
                out_data_d  = mode_q ? DW'(win_sum / SW'(K * K)) : win_max;
            end
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row_q        <= '0;
            col_q        <= '0;
            mode_q       <= 1'b0;
            busy_q       <= 1'b0;
            ocnt_q       <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            frame_done_q <= 1'b0;
        end else begin
            row_q        <= row_d;
            col_q        <= col_d;
            mode_q       <= mode_d;
            busy_q       <= busy_d;
            ocnt_q       <= ocnt_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            frame_done_q <= frame_done_d;
        end
    end

endmodule

`default_nettype wire

// File: doc/pool2d_stream.md
Name: pool2d_stream

Overview:
- Streaming 2-D pooling engine for the CNN feature-map path.
- Accepts one feature-map pixel per cycle in raster order over a valid/ready interface.
- Buffers K-1 rows internally and emits one pooled pixel per K×K window at stride S, in MAX or AVG mode (no padding).
- Drops between the conv/activation stage and the next layer, replacing whole-frame-in-parallel pooling.

Parameters:
- DW, 8, pixel data width (unsigned)
- IMG_W, 8, input feature-map width in pixels
- IMG_H, 8, input feature-map height in pixels
- K, 3, pooling window side (2..IMG_W, K<=IMG_H)
- S, 1, stride (1..K)

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  asynchronous reset, active-low (asserts immediately when low, deassertion synchronous to clk)
- mode  in  1  0 = MAX, 1 = AVG; latched when first pixel of a frame is accepted
- in_valid  in  1  input pixel valid
- in_ready  out  1  block can accept a pixel
- in_data  in  DW  input pixel
- out_valid  out  1  pooled pixel valid
- out_ready  in  1  downstream accepts pooled pixel
- out_data  out  DW  pooled pixel
- frame_done  out  1  one-cycle pulse when last pooled pixel of a frame is accepted downstream
- busy  out  1  high from first accepted pixel of a frame until frame_done

Behaviour:
- Reset (rst low): out_valid=0, out_data=0, frame_done=0, busy=0, in_ready=1 once released. Row/col counters=0, latched mode=MAX. Line-buffer/window contents need not be cleared.
- Output geometry: OW=(IMG_W-K)/S+1, OH=(IMG_H-K)/S+1 (integer floor). Trailing rows/cols not covered by a full window are consumed and discarded.
- Input handshake: pixel accepted on cycle where in_valid && in_ready.
  - in_ready = !out_valid || out_ready (single output register, no skid).
- Accepted pixel at (r,c): written into line buffer; K×K window shift register updated. c increments and wraps to 0 at IMG_W-1, incrementing r. Frame ends after pixel (IMG_H-1, IMG_W-1); counters return to 0.
- Window emit condition, on the pixel at (r,c):
  - r>=K-1 and c>=K-1
  - (r-K+1)%S==0 and (c-K+1)%S==0
- Window contents = rows r-K+1..r, cols c-K+1..c (current pixel included).
- Latency: out_valid rises the cycle after the completing pixel is accepted. out_data is held stable while out_valid && !out_ready.
- MAX mode: out_data = maximum of K*K unsigned elements.
- AVG mode: sum in DW+clog2(K*K) bits, no overflow; out_data = floor(sum/(K*K)). Result always fits DW.
- mode is sampled only on the first pixel of a frame; changes mid-frame are ignored until next frame.
- frame_done pulses on the cycle the OH*OW-th output handshake completes; busy clears the same cycle.
- Simultaneous output accept and new emitting pixel: new result loads the same cycle, with no bubble. Sustained throughput is 1 pixel/cycle when out_ready=1.
- in_valid low: counters hold; no output generated.
- Reset mid-frame: frame discarded, no partial output; next frame starts at (0,0).
- Elaboration must fail (generate-time error) if K>IMG_W, K>IMG_H, S<1 or S>K.

Test Plan:
- Defaults, MAX, ramp in_data=r*8+c, out_ready=1 → 36 outputs, out(i,j)=(i+2)*8+j+2; first=18, last=63; one frame_done pulse after 36th.
- Defaults, AVG, same ramp → out(i,j)=(i+1)*8+j+1; first=9, last=54; all-255 frame → every output 255 (no overflow).
- K=2,S=2, IMG 8×8, MAX, ramp → 16 outputs, out(i,j)=(2i+1)*8+2j+1; first=9, last=63.
- Backpressure: hold out_ready=0 for 5 cycles mid-frame → in_ready=0 while output held; out_data stable; no lost/duplicated outputs; sequence matches first scenario.
- Assert rst low mid-frame at pixel 30 → out_valid/busy drop immediately. Second full frame afterwards gives exactly the 36 correct outputs.
- Toggle mode MAX→AVG at pixel 20 → whole frame MAX. Next frame with mode=1 → AVG results.
